rx_cmd_ctrl: RTL and testbench

RX_CMD_CTRL -- requirements
Module: rx_cmd_ctrl

---
 rtl/rx_cmd_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_rx_cmd_ctrl.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_ctrl.sv
// Byte-stream command controller: decodes RX command bytes into register-file
// writes/reads and ALU operations, and returns read data or ALU results to the TX FIFO.
module rx_cmd_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   rx_p_data,
  input  logic                    rx_d_vld,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_data_vld,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_vld,
  input  logic                    fifo_full,
  output logic                    rf_wr_en,
  output logic                    rf_rd_en,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic                    alu_en,
  output logic [3:0]              alu_fun,
  output logic                    clk_gate_en,
  output logic                    tx_wr_en,
  output logic [DATA_WIDTH-1:0]   tx_wr_data
);

  localparam int unsigned RES_WIDTH = 2 * DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    ALU_FUN,
    ALU_WAIT,
    TX_LSB,
    TX_MSB
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  rd_data_q;
  logic                   rd_have;
  logic [RES_WIDTH-1:0]   alu_q;

  // Command sequencer; strobes default low each cycle so every strobe is a single-cycle pulse
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      addr_q      <= '0;
      rd_data_q   <= '0;
      rd_have     <= 1'b0;
      alu_q       <= '0;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_addr     <= '0;
      rf_wr_data  <= '0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      clk_gate_en <= 1'b0;
      tx_wr_en    <= 1'b0;
      tx_wr_data  <= '0;
    end else begin
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      alu_en   <= 1'b0;
      tx_wr_en <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_d_vld) begin
            case (rx_p_data)
              CMD_WR:  state <= WR_ADDR;
              CMD_RD:  state <= RD_ADDR;
              CMD_OP:  state <= OP_A;
              CMD_FUN: begin
                state       <= ALU_FUN;
                clk_gate_en <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end
        end

        WR_ADDR: begin
          if (rx_d_vld) begin
            addr_q <= ADDR_WIDTH'(rx_p_data);
            state  <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (rx_d_vld) begin
            rf_wr_en   <= 1'b1;
            rf_addr    <= addr_q;
            rf_wr_data <= rx_p_data;
            state      <= IDLE;
          end
        end

        RD_ADDR: begin
          if (rx_d_vld) begin
            rf_rd_en <= 1'b1;
            rf_addr  <= ADDR_WIDTH'(rx_p_data);
            state    <= RD_WAIT;
          end
        end

        // Fresh read data bypasses the capture register so an unblocked FIFO sees it next cycle
        RD_WAIT: begin
          if (rf_rd_data_vld || rd_have) begin
            if (rf_rd_data_vld) begin
              rd_data_q <= rf_rd_data;
            end
            if (!fifo_full) begin
              tx_wr_en   <= 1'b1;
              tx_wr_data <= rf_rd_data_vld ? rf_rd_data : rd_data_q;
              rd_have    <= 1'b0;
              state      <= IDLE;
            end else begin
              rd_have <= 1'b1;
            end
          end
        end

        OP_A: begin
          if (rx_d_vld) begin
            rf_wr_en   <= 1'b1;
            rf_addr    <= '0;
            rf_wr_data <= rx_p_data;
            state      <= OP_B;
          end
        end

        OP_B: begin
          if (rx_d_vld) begin
            rf_wr_en    <= 1'b1;
            rf_addr     <= ADDR_WIDTH'(1);
            rf_wr_data  <= rx_p_data;
            clk_gate_en <= 1'b1;
            state       <= ALU_FUN;
          end
        end

        ALU_FUN: begin
          if (rx_d_vld) begin
            alu_en  <= 1'b1;
            alu_fun <= 4'(rx_p_data);
            state   <= ALU_WAIT;
          end
        end

        ALU_WAIT: begin
          if (alu_out_vld) begin
            alu_q       <= alu_out;
            clk_gate_en <= 1'b0;
            state       <= TX_LSB;
          end
        end

        TX_LSB: begin
          if (!fifo_full) begin
            tx_wr_en   <= 1'b1;
            tx_wr_data <= alu_q[DATA_WIDTH-1:0];
            state      <= TX_MSB;
          end
        end

        // Skip the cycle carrying the low-byte write so the FIFO can update fifo_full first
        TX_MSB: begin
          if (!fifo_full && !tx_wr_en) begin
            tx_wr_en   <= 1'b1;
            tx_wr_data <= alu_q[RES_WIDTH-1:DATA_WIDTH];
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Bench for rx_cmd_ctrl: directed scenarios plus randomized command streams checked
// against a command-level model; the environment plays register file and ALU.
`timescale 1ns/1ps
module tb_rx_cmd_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] rx_p_data;
  logic          rx_d_vld;
  logic [DW-1:0] rf_rd_data;
  logic          rf_rd_data_vld;
  logic [2*DW-1:0] alu_out;
  logic          alu_out_vld;
  logic          fifo_full;
  logic          rf_wr_en;
  logic          rf_rd_en;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wr_data;
  logic          alu_en;
  logic [3:0]    alu_fun;
  logic          clk_gate_en;
  logic          tx_wr_en;
  logic [DW-1:0] tx_wr_data;

  rx_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .rx_p_data(rx_p_data), .rx_d_vld(rx_d_vld),
    .rf_rd_data(rf_rd_data), .rf_rd_data_vld(rf_rd_data_vld),
    .alu_out(alu_out), .alu_out_vld(alu_out_vld),
    .fifo_full(fifo_full),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
    .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Observed strobe events, in order: {type, addr/fun, data}
  logic [13:0] q_ev[$];
  int tx_count = 0;
  int viol_overlap = 0, viol_full = 0, viol_width = 0, viol_hold = 0;
  int tx_cyc_last = 0, vld_cyc_last = 0, alu_seen = 0;
  logic cg_at_alu_en = 1'b0, cg_at_alu_vld = 1'b0;

  // Environment register file and ALU, plus the command-level reference memory
  logic [7:0] mem [16];
  logic [7:0] model_mem [16];
  bit         alu_force = 1'b0;
  logic [15:0] alu_force_val = '0;
  int         alu_delay = -1;

  function automatic logic [13:0] ev_wr(input logic [3:0] a, input logic [7:0] d);
    return {2'd0, a, d};
  endfunction
  function automatic logic [13:0] ev_rd(input logic [3:0] a);
    return {2'd1, a, 8'h00};
  endfunction
  function automatic logic [13:0] ev_alu(input logic [3:0] f);
    return {2'd2, f, 8'h00};
  endfunction
  function automatic logic [13:0] ev_tx(input logic [7:0] d);
    return {2'd3, 4'h0, d};
  endfunction

  function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {a, b};
      default: return {a & b, a | b};
    endcase
  endfunction

  task automatic monitor();
    logic [3:0] str, prev_str;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd, p_tx;
    logic [3:0] p_fun;
    prev_str = '0; p_addr = '0; p_wd = '0; p_tx = '0; p_fun = '0;
    forever begin
      @(negedge CLK);
      str = {rf_wr_en, rf_rd_en, alu_en, tx_wr_en};
      if (RST) begin
        if ($countones(str) > 1) viol_overlap++;
        if (tx_wr_en && fifo_full) viol_full++;
        if ((str & prev_str) != 4'b0) viol_width++;
        if (!(rf_wr_en || rf_rd_en) && rf_addr !== p_addr) viol_hold++;
        if (!rf_wr_en && rf_wr_data !== p_wd) viol_hold++;
        if (!alu_en && alu_fun !== p_fun) viol_hold++;
        if (!tx_wr_en && tx_wr_data !== p_tx) viol_hold++;
        if (rf_wr_en) q_ev.push_back(ev_wr(rf_addr, rf_wr_data));
        if (rf_rd_en) q_ev.push_back(ev_rd(rf_addr));
        if (alu_en) begin
          q_ev.push_back(ev_alu(alu_fun));
          cg_at_alu_en = clk_gate_en;
        end
        if (tx_wr_en) begin
          q_ev.push_back(ev_tx(tx_wr_data));
          tx_count++;
          tx_cyc_last = cyc;
        end
        prev_str = str;
      end else begin
        prev_str = '0;
      end
      p_addr = rf_addr; p_wd = rf_wr_data; p_fun = alu_fun; p_tx = tx_wr_data;
    end
  endtask

  task automatic responder();
    int rd_cnt, alu_cnt;
    logic [3:0] rd_a, fn;
    rd_cnt = -1; alu_cnt = -1; rd_a = '0; fn = '0;
    forever begin
      @(negedge CLK);
      rf_rd_data_vld = 1'b0;
      alu_out_vld    = 1'b0;
      rf_rd_data     = 8'($urandom);
      if (RST && rf_wr_en) mem[rf_addr] = rf_wr_data;
      if (RST && rf_rd_en) begin
        rd_a = rf_addr;
        rd_cnt = $urandom_range(0, 3);
      end
      if (RST && alu_en) begin
        fn = alu_fun;
        alu_cnt = (alu_delay >= 0) ? alu_delay : $urandom_range(0, 3);
      end
      if (rd_cnt == 0) begin
        rf_rd_data = mem[rd_a];
        rf_rd_data_vld = 1'b1;
        vld_cyc_last = cyc;
      end
      if (rd_cnt >= 0) rd_cnt--;
      if (alu_cnt == 0) begin
        alu_out = alu_force ? alu_force_val : alu_ref(fn, mem[0], mem[1]);
        alu_out_vld = 1'b1;
        cg_at_alu_vld = clk_gate_en;
        alu_seen++;
      end
      if (alu_cnt >= 0) alu_cnt--;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge CLK);
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    @(negedge CLK);
    rx_d_vld  = 1'b0;
    rx_p_data = 8'($urandom);
    repeat (gap) @(negedge CLK);
  endtask

  task automatic clear_events();
    q_ev.delete();
    tx_count = 0;
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (tx_count >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #3 RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_wr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 00000", {rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_wr_en});
    end
    checks++;
    if ({rf_addr, rf_wr_data, alu_fun, tx_wr_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {rf_addr, rf_wr_data, alu_fun, tx_wr_data});
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (q_ev.size() != 0) begin
      errors++;
      $display("FAIL reset_release_idle: got %0d events want 0", q_ev.size());
    end
  endtask

  task automatic test_write();
    logic [13:0] exp[$];
    bit ok, same;
    clear_events();
    send_byte(8'hAA, $urandom_range(0, 2));
    send_byte(8'h05, $urandom_range(0, 2));
    send_byte(8'h3C, $urandom_range(0, 2));
    wait_tx(0, ok);
    model_mem[5] = 8'h3C;
    exp = '{ev_wr(4'h5, 8'h3C)};
    same = (q_ev.size() == exp.size());
    foreach (exp[i]) if (same && q_ev[i] !== exp[i]) same = 1'b0;
    checks++;
    if (!same) begin
      errors++;
      $display("FAIL write_events: got %p want %p", q_ev, exp);
    end
  endtask

  task automatic test_read();
    logic [13:0] exp[$];
    bit ok, same;
    clear_events();
    mem[7] = 8'h5A;
    model_mem[7] = 8'h5A;
    send_byte(8'hBB, $urandom_range(0, 2));
    send_byte(8'h07, 0);
    wait_tx(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL read_timeout: got %0d tx want 1", tx_count);
    end
    exp = '{ev_rd(4'h7), ev_tx(8'h5A)};
    same = (q_ev.size() == exp.size());
    foreach (exp[i]) if (same && q_ev[i] !== exp[i]) same = 1'b0;
    checks++;
    if (!same) begin
      errors++;
      $display("FAIL read_events: got %p want %p", q_ev, exp);
    end
    checks++;
    if (tx_cyc_last - vld_cyc_last != 1) begin
      errors++;
      $display("FAIL read_latency: got %0d cycles want 1", tx_cyc_last - vld_cyc_last);
    end
  endtask

  task automatic test_alu();
    logic [13:0] exp[$];
    bit ok, same;
    clear_events();
    checks++;
    if (clk_gate_en !== 1'b0) begin
      errors++;
      $display("FAIL alu_gate_before: got %b want 0", clk_gate_en);
    end
    send_byte(8'hCC, $urandom_range(0, 2));
    send_byte(8'h0A, $urandom_range(0, 2));
    send_byte(8'h0B, $urandom_range(0, 2));
    checks++;
    if (clk_gate_en !== 1'b1) begin
      errors++;
      $display("FAIL alu_gate_in_fun: got %b want 1", clk_gate_en);
    end
    send_byte(8'h00, 0);
    wait_tx(2, ok);
    model_mem[0] = 8'h0A;
    model_mem[1] = 8'h0B;
    exp = '{ev_wr(4'h0, 8'h0A), ev_wr(4'h1, 8'h0B), ev_alu(4'h0), ev_tx(8'h15), ev_tx(8'h00)};
    same = ok && (q_ev.size() == exp.size());
    foreach (exp[i]) if (same && q_ev[i] !== exp[i]) same = 1'b0;
    checks++;
    if (!same) begin
      errors++;
      $display("FAIL alu_events: got %p want %p", q_ev, exp);
    end
    checks++;
    if ({cg_at_alu_en, cg_at_alu_vld, clk_gate_en} !== 3'b110) begin
      errors++;
      $display("FAIL alu_gate_window: got %b want 110", {cg_at_alu_en, cg_at_alu_vld, clk_gate_en});
    end
  endtask

  task automatic test_alu_fifo_full();
    logic [13:0] exp[$];
    bit ok, same, seen;
    int start;
    clear_events();
    alu_force = 1'b1;
    alu_force_val = 16'h1234;
    send_byte(8'hDD, $urandom_range(0, 2));
    fifo_full = 1'b1;
    start = alu_seen;
    send_byte(8'h02, 0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (alu_seen != start) seen = 1'b1;
      else @(negedge CLK);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL full_alu_timeout: got %0d results want 1", alu_seen - start);
    end
    repeat (5) @(negedge CLK);
    checks++;
    if (tx_count != 0) begin
      errors++;
      $display("FAIL full_no_tx: got %0d tx want 0", tx_count);
    end
    fifo_full = 1'b0;
    wait_tx(2, ok);
    exp = '{ev_alu(4'h2), ev_tx(8'h34), ev_tx(8'h12)};
    same = ok && (q_ev.size() == exp.size());
    foreach (exp[i]) if (same && q_ev[i] !== exp[i]) same = 1'b0;
    checks++;
    if (!same) begin
      errors++;
      $display("FAIL full_events: got %p want %p", q_ev, exp);
    end
    alu_force = 1'b0;
  endtask

  task automatic test_ignore();
    logic [13:0] exp[$];
    bit ok, same;
    clear_events();
    send_byte(8'h77, 3);
    checks++;
    if (q_ev.size() != 0 || clk_gate_en !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: got %0d events gate %b want 0 events gate 0", q_ev.size(), clk_gate_en);
    end
    alu_delay = 12;
    send_byte(8'hCC, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h03, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h05, 0);
    send_byte(8'hBB, 0);
    wait_tx(2, ok);
    alu_delay = -1;
    model_mem[0] = 8'h11;
    model_mem[1] = 8'h22;
    send_byte(8'hAA, 0);
    send_byte(8'h03, 0);
    send_byte(8'h44, 0);
    wait_tx(2, ok);
    model_mem[3] = 8'h44;
    exp = '{ev_wr(4'h0, 8'h11), ev_wr(4'h1, 8'h22), ev_alu(4'h3), ev_tx(8'h22), ev_tx(8'h11),
            ev_wr(4'h3, 8'h44)};
    same = ok && (q_ev.size() == exp.size());
    foreach (exp[i]) if (same && q_ev[i] !== exp[i]) same = 1'b0;
    checks++;
    if (!same) begin
      errors++;
      $display("FAIL ignore_events: got %p want %p", q_ev, exp);
    end
  endtask

  task automatic test_reset_mid_cmd();
    logic [13:0] exp[$];
    bit ok, same;
    clear_events();
    send_byte(8'hAA, 0);
    send_byte(8'h05, 0);
    #2 RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({rf_wr_en, rf_rd_en, alu_en, tx_wr_en, rf_addr, rf_wr_data, tx_wr_data} !== 28'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h want 0", {rf_wr_en, rf_rd_en, alu_en, tx_wr_en, rf_addr, rf_wr_data, tx_wr_data});
    end
    #2 RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({rf_wr_en, rf_rd_en, alu_en, tx_wr_en} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_first_cycle: got %b want 0000", {rf_wr_en, rf_rd_en, alu_en, tx_wr_en});
    end
    send_byte(8'hAA, 0);
    send_byte(8'h01, 1);
    send_byte(8'hFF, 0);
    wait_tx(0, ok);
    model_mem[1] = 8'hFF;
    exp = '{ev_wr(4'h1, 8'hFF)};
    same = (q_ev.size() == exp.size());
    foreach (exp[i]) if (same && q_ev[i] !== exp[i]) same = 1'b0;
    checks++;
    if (!same) begin
      errors++;
      $display("FAIL midreset_events: got %p want %p", q_ev, exp);
    end
  endtask

  task automatic test_random();
    logic [13:0] exp[$];
    logic [7:0]  bytes[$];
    for (int n = 0; n < 40; n++) begin
      int k, stall, n_tx;
      logic [7:0] a, b, f, j;
      logic [15:0] r;
      bit ok, same;
      clear_events();
      exp.delete();
      bytes.delete();
      repeat ($urandom_range(0, 2)) begin
        do j = 8'($urandom); while (j == 8'hAA || j == 8'hBB || j == 8'hCC || j == 8'hDD);
        bytes.push_back(j);
      end
      k = $urandom_range(0, 3);
      a = 8'($urandom);
      b = 8'($urandom);
      f = 8'($urandom);
      n_tx = 2;
      case (k)
        0: begin
          bytes.push_back(8'hAA); bytes.push_back(a); bytes.push_back(b);
          exp.push_back(ev_wr(a[3:0], b));
          model_mem[a[3:0]] = b;
          n_tx = 0;
        end
        1: begin
          bytes.push_back(8'hBB); bytes.push_back(a);
          exp.push_back(ev_rd(a[3:0]));
          exp.push_back(ev_tx(model_mem[a[3:0]]));
          n_tx = 1;
        end
        2: begin
          bytes.push_back(8'hCC); bytes.push_back(a); bytes.push_back(b); bytes.push_back(f);
          model_mem[0] = a;
          model_mem[1] = b;
          r = alu_ref(f[3:0], a, b);
          exp.push_back(ev_wr(4'h0, a));
          exp.push_back(ev_wr(4'h1, b));
          exp.push_back(ev_alu(f[3:0]));
          exp.push_back(ev_tx(r[7:0]));
          exp.push_back(ev_tx(r[15:8]));
        end
        default: begin
          bytes.push_back(8'hDD); bytes.push_back(f);
          r = alu_ref(f[3:0], model_mem[0], model_mem[1]);
          exp.push_back(ev_alu(f[3:0]));
          exp.push_back(ev_tx(r[7:0]));
          exp.push_back(ev_tx(r[15:8]));
        end
      endcase
      stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      foreach (bytes[i]) begin
        if (i == bytes.size() - 1 && stall > 0) fifo_full = 1'b1;
        send_byte(bytes[i], $urandom_range(0, 2));
      end
      repeat (stall) @(negedge CLK);
      fifo_full = 1'b0;
      wait_tx(n_tx, ok);
      same = ok && (q_ev.size() == exp.size());
      foreach (exp[i]) if (same && q_ev[i] !== exp[i]) same = 1'b0;
      checks++;
      if (!same) begin
        errors++;
        $display("FAIL random_cmd%0d kind %0d stall %0d: got %p want %p", n, k, stall, q_ev, exp);
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol_overlap != 0) begin
      errors++;
      $display("FAIL strobe_overlap: got %0d want 0", viol_overlap);
    end
    checks++;
    if (viol_full != 0) begin
      errors++;
      $display("FAIL tx_while_full: got %0d want 0", viol_full);
    end
    checks++;
    if (viol_width != 0) begin
      errors++;
      $display("FAIL strobe_width: got %0d want 0", viol_width);
    end
    checks++;
    if (viol_hold != 0) begin
      errors++;
      $display("FAIL data_hold: got %0d want 0", viol_hold);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rx_p_data = '0;
    rx_d_vld = 1'b0;
    rf_rd_data = '0;
    rf_rd_data_vld = 1'b0;
    alu_out = '0;
    alu_out_vld = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      model_mem[i] = '0;
    end
    fork
      monitor();
      responder();
    join_none
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_alu_fifo_full();
    test_ignore();
    test_reset_mid_cmd();
    test_random();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
